// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: opcode constants, FSM state encoding, default PC width.
package fetch_seq_pkg;

    localparam int unsigned PC_W_DEF = 7;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_RUN     = 3'd1,
        ST_BR_WAIT = 3'd2,
        ST_REFILL  = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage control bundle between the sequencer (slave) and the fetch datapath (master).
// FETCH_SEQ_STATS_EN adds the bubble_cnt statistics signal.
interface fetch_sequencer_if
    import fetch_seq_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
);
    logic [31:0]     instr;
    logic            stall_in;
    logic            br_resolved;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            pc_en;
    logic            pc_sel;
    logic [PC_W-1:0] pc_target;
    logic            if_id_en;
    logic            bubble;
    logic            halted;
    logic            err;
`ifdef FETCH_SEQ_STATS_EN
    logic [15:0]     bubble_cnt;
`endif

    modport slave (
        input  instr, stall_in, br_resolved, br_taken, br_target,
        output pc_en, pc_sel, pc_target, if_id_en, bubble, halted,
`ifdef FETCH_SEQ_STATS_EN
        output bubble_cnt,
`endif
        output err
    );

    modport master (
        output instr, stall_in, br_resolved, br_taken, br_target,
        input  pc_en, pc_sel, pc_target, if_id_en, bubble, halted,
`ifdef FETCH_SEQ_STATS_EN
        input  bubble_cnt,
`endif
        input  err
    );

endinterface

// File: rtl/fetch_sequencer_branch_decode.sv
// Combinational opcode classifier for the word presented by instruction memory.
module branch_decode
    import fetch_seq_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) (
    input  logic [31:0]     instr,
    output logic            is_jump,
    output logic            is_branch,
    output logic            is_halt,
    output logic [PC_W-1:0] jump_target
);
    logic [5:0] opcode_s;
    logic       unused_bits_s;

    assign opcode_s      = opcode_of(instr);
    assign is_jump       = (opcode_s == OP_J);
    assign is_branch     = (opcode_s == OP_BEQ) || (opcode_s == OP_BNE);
    assign is_halt       = (opcode_s == OP_HALT);
    assign jump_target   = instr[PC_W-1:0];
    // Operand bits above the jump target carry no control meaning here.
    assign unused_bits_s = ^instr[25:PC_W];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: PC enable/select, IF/ID bubbles, branch wait with timeout, halt.
// Optional FETCH_SEQ_STATS_EN adds a saturating bubble-cycle counter on the interface.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned PC_W     = PC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.slave   bus
);
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t          state_r;
    logic [7:0]      wait_cnt_r;
    logic            err_r;

    logic            is_jump_s;
    logic            is_branch_s;
    logic            is_halt_s;
    logic [PC_W-1:0] jump_target_s;

    logic            pc_en_s;
    logic            pc_sel_s;
    logic [PC_W-1:0] pc_target_s;
    logic            if_id_en_s;
    logic            bubble_s;
    logic            halted_s;

    branch_decode #(.PC_W(PC_W)) u_decode (
        .instr       (bus.instr),
        .is_jump     (is_jump_s),
        .is_branch   (is_branch_s),
        .is_halt     (is_halt_s),
        .jump_target (jump_target_s)
    );

    // State, branch-wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RESET;
            wait_cnt_r <= 8'd0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_RESET: state_r <= ST_RUN;
                ST_RUN: begin
                    if (!bus.stall_in) begin
                        if (is_jump_s) begin
                            state_r <= ST_REFILL;
                        end else if (is_branch_s) begin
                            state_r    <= ST_BR_WAIT;
                            wait_cnt_r <= 8'd0;
                        end else if (is_halt_s) begin
                            state_r <= ST_HALT;
                        end
                    end
                end
                ST_BR_WAIT: begin
                    // Resolution wins over timeout on the final wait cycle.
                    if (bus.br_resolved) begin
                        state_r <= bus.br_taken ? ST_REFILL : ST_RUN;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        err_r   <= 1'b1;
                        state_r <= ST_HALT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                ST_REFILL: state_r <= ST_RUN;
                ST_HALT:   state_r <= ST_HALT;
                default:   state_r <= ST_RESET;
            endcase
        end
    end

    // Datapath controls decoded from state, current memory word and branch resolution.
    always_comb begin
        pc_en_s     = 1'b0;
        pc_sel_s    = 1'b0;
        pc_target_s = '0;
        if_id_en_s  = 1'b1;
        bubble_s    = 1'b1;
        halted_s    = 1'b0;
        case (state_r)
            ST_RESET: begin
                bubble_s = 1'b1;
            end
            ST_RUN: begin
                bubble_s = 1'b0;
                if (bus.stall_in) begin
                    if_id_en_s = 1'b0;
                end else if (is_jump_s) begin
                    pc_en_s     = 1'b1;
                    pc_sel_s    = 1'b1;
                    pc_target_s = jump_target_s;
                end else if (is_branch_s || is_halt_s) begin
                    pc_en_s = 1'b0;
                end else begin
                    pc_en_s = 1'b1;
                end
            end
            ST_BR_WAIT: begin
                if (bus.br_resolved && bus.br_taken) begin
                    pc_en_s     = 1'b1;
                    pc_sel_s    = 1'b1;
                    pc_target_s = bus.br_target;
                end else begin
                    pc_en_s = 1'b0;
                end
            end
            ST_REFILL: begin
                pc_en_s = 1'b1;
            end
            ST_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                pc_en_s = 1'b0;
            end
        endcase
    end

`ifdef FETCH_SEQ_STATS_EN
    logic [15:0] bubble_cnt_r;

    // Saturating count of bubble cycles outside the post-reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_r <= 16'd0;
        end else if (bubble_s && (state_r != ST_RESET) && (bubble_cnt_r != 16'hFFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 16'd1;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_r;
`endif

    assign bus.pc_en     = pc_en_s;
    assign bus.pc_sel    = pc_sel_s;
    assign bus.pc_target = pc_target_s;
    assign bus.if_id_en  = if_id_en_s;
    assign bus.bubble    = bubble_s;
    assign bus.halted    = halted_s;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: each driven cycle queues its expected controls, checked at negedge.
module tb_fetch_sequencer;

    typedef struct packed {
        logic       pc_en;
        logic       pc_sel;
        logic [6:0] pc_target;
        logic       if_id_en;
        logic       bubble;
        logic       halted;
        logic       err;
    } outs_t;

    typedef struct {
        string tag;
        outs_t exp;
    } sb_t;

    localparam logic [31:0] I_SEQ  = {6'h08, 26'h0000123};
    localparam logic [31:0] I_J40  = {6'h02, 19'h0, 7'h40};
    localparam logic [31:0] I_BEQ  = {6'h04, 26'h0000011};
    localparam logic [31:0] I_BNE  = {6'h05, 26'h0000022};
    localparam logic [31:0] I_HALT = {6'h3F, 26'h0};

    //                                   en    sel   target  ifid  bub   halt  err
    localparam outs_t O_RST   = {1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam outs_t O_SEQ   = {1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam outs_t O_DEC   = {1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam outs_t O_STALL = {1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam outs_t O_JMP   = {1'b1, 1'b1, 7'h40, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam outs_t O_WAIT  = {1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam outs_t O_TAKEN = {1'b1, 1'b1, 7'h10, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam outs_t O_REFIL = {1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam outs_t O_HALT  = {1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam outs_t O_HERR  = {1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic rst;
    int   checks_total  = 0;
    int   checks_passed = 0;
    sb_t  sb_q[$];

    fetch_sequencer_if #(.PC_W(7)) bus ();

    fetch_sequencer #(.MAX_WAIT(4), .PC_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and queue what the controls must be during that cycle.
    task automatic step(input string tag, input logic [31:0] i, input logic st,
                        input logic rr, input logic rt, input logic [6:0] tg, input outs_t exp);
        bus.instr       = i;
        bus.stall_in    = st;
        bus.br_resolved = rr;
        bus.br_taken    = rt;
        bus.br_target   = tg;
        sb_q.push_back('{tag: tag, exp: exp});
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t e;
            outs_t obs;
            e   = sb_q.pop_front();
            obs = {bus.pc_en, bus.pc_sel, bus.pc_target, bus.if_id_en, bus.bubble, bus.halted, bus.err};
            check_eq(e.tag, {19'd0, obs}, {19'd0, e.exp});
        end
    end

    initial begin
        rst             = 1'b1;
        bus.instr       = I_SEQ;
        bus.stall_in    = 1'b0;
        bus.br_resolved = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 7'h00;
        @(posedge clk);
        #1;
        apply_reset();

        step("reset_cycle", I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_RST);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("seq_%0d", k), I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_SEQ);
        end

        step("jump",        I_J40, 1'b0, 1'b0, 1'b0, 7'h00, O_JMP);
        step("jump_refill", I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_REFIL);
        step("jump_run",    I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_SEQ);

        step("beq_decode",  I_BEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_DEC);
        step("beq_wait1",   I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_WAIT);
        step("beq_wait2",   I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_WAIT);
        step("beq_taken",   I_SEQ, 1'b0, 1'b1, 1'b1, 7'h10, O_TAKEN);
        step("beq_refill",  I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_REFIL);
        step("beq_run",     I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_SEQ);

        step("bne_decode",  I_BNE, 1'b0, 1'b0, 1'b0, 7'h00, O_DEC);
        step("bne_wait1",   I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_WAIT);
        step("bne_wait2",   I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_WAIT);
        step("bne_nottaken", I_SEQ, 1'b0, 1'b1, 1'b0, 7'h33, O_WAIT);
        step("bne_run",     I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_SEQ);

        step("stall_1",     I_BNE, 1'b1, 1'b0, 1'b0, 7'h00, O_STALL);
        step("stall_2",     I_BNE, 1'b1, 1'b0, 1'b0, 7'h00, O_STALL);
        step("stall_rel",   I_BNE, 1'b0, 1'b0, 1'b0, 7'h00, O_DEC);
        step("wait_stall",  I_SEQ, 1'b1, 1'b0, 1'b0, 7'h00, O_WAIT);
        step("wait_resolve", I_SEQ, 1'b0, 1'b1, 1'b0, 7'h00, O_WAIT);
        step("run_ign_res", I_SEQ, 1'b0, 1'b1, 1'b1, 7'h55, O_SEQ);

        step("to_decode",   I_BEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_DEC);
        for (int k = 0; k < 4; k++) begin
            step($sformatf("to_wait%0d", k + 1), I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_WAIT);
        end
        step("to_halt_err", I_SEQ, 1'b0, 1'b0, 1'b0, 7'h00, O_HERR);
        step("to_halt_res", I_SEQ, 1'b0, 1'b1, 1'b1, 7'h10, O_HERR);

        apply_reset();
        step("rst_clears",  I_SEQ,  1'b0, 1'b0, 1'b0, 7'h00, O_RST);
        step("halt_decode", I_HALT, 1'b0, 1'b0, 1'b0, 7'h00, O_DEC);
        step("halt_res",    I_SEQ,  1'b0, 1'b1, 1'b1, 7'h10, O_HALT);
        step("halt_hold",   I_J40,  1'b0, 1'b0, 1'b0, 7'h00, O_HALT);

        @(negedge clk);
        #1;
        check_eq("sb_drain", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control FSM for the instruction fetch stage. It decodes the word returned by the synchronous instruction memory and drives the PC enable and PC source select. It inserts bubbles into the IF/ID latch while a conditional branch is unresolved, and handles jumps, downstream stalls, halt and a branch-resolution timeout. It sits between the fetch datapath (PC register, incrementer, PC mux, 128×32 instruction memory) and the execute stage that resolves branches.

## Interface
Parameters:
- MAX_WAIT, 8, max cycles in BR_WAIT before timeout (1..255)
- PC_W, 7, PC width

Ports (reset rst, synchronous, active-high):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction memory data out; one-cycle read latency
- stall_in  in  1  downstream hazard stall; freezes PC and IF/ID
- br_resolved  in  1  execute stage has resolved the pending branch (1-cycle pulse)
- br_taken  in  1  qualified by br_resolved
- br_target  in  PC_W  qualified by br_resolved & br_taken
- pc_en  out  1  PC register load enable
- pc_sel  out  1  0: PC+1, 1: pc_target
- pc_target  out  PC_W  redirect address
- if_id_en  out  1  IF/ID latch load enable
- bubble  out  1  IF/ID loads a NOP instead of instr
- halted  out  1  HALT state
- err  out  1  sticky timeout flag; cleared only by rst

## Operation
- Opcode is instr[31:26]. OP_J=6'h02 (target instr[PC_W-1:0]), OP_BEQ=6'h04, OP_BNE=6'h05, OP_HALT=6'h3F. All other opcodes are sequential.
- States: RESET, RUN, BR_WAIT, REFILL, HALT.
- RESET
  - Entered on any cycle with rst=1, including mid-operation. Wait counter cleared, err cleared.
  - Outputs: pc_en=0, if_id_en=1, bubble=1, pc_sel=0. Exactly one cycle, then RUN.
- RUN
  - stall_in=1: pc_en=0, if_id_en=0, no state change, instr not decoded.
  - stall_in=0, sequential opcode: pc_en=1, if_id_en=1, bubble=0.
  - stall_in=0, OP_J: pc_en=1, pc_sel=1, pc_target=instr[PC_W-1:0], if_id_en=1, bubble=0 (jump passes down). Next state REFILL.
  - stall_in=0, BEQ/BNE: pc_en=0, if_id_en=1, bubble=0 (branch passes down). Next state BR_WAIT, counter=0.
  - stall_in=0, OP_HALT: pc_en=0, if_id_en=1, bubble=0. Next state HALT.
- BR_WAIT
  - pc_en=0, if_id_en=1, bubble=1. stall_in ignored.
  - br_resolved & br_taken: pc_en=1, pc_sel=1, pc_target=br_target. Next state REFILL.
  - br_resolved & ~br_taken: pc_en=0. Memory already presents mem[PC], the fall-through word. Next state RUN.
  - No resolution: counter++. When counter reaches MAX_WAIT-1 without resolution, err<=1 and next state HALT.
- REFILL: discards the stale memory word. pc_en=1, pc_sel=0, if_id_en=1, bubble=1, one cycle, then RUN.
- HALT: pc_en=0, if_id_en=1, bubble=1, halted=1. Only rst exits.
- br_resolved outside BR_WAIT is ignored.

## Timing
- Reset values (cycle after rst sampled): state RESET, pc_en=0, pc_sel=0, pc_target=0, if_id_en=1, bubble=1, halted=0, err=0.
- Outputs are combinational from state, instr, stall_in and br_*. State, counter and err are registered.
- Jump penalty: 1 bubble. Taken-branch penalty: N+1 bubbles, where N = cycles in BR_WAIT. Not-taken penalty: N bubbles.
- Timeout fires on the MAX_WAIT-th BR_WAIT cycle. err and halted assert the following cycle.

## Configuration
- FETCH_SEQ_STATS_EN defined: adds output bubble_cnt[15:0] counting cycles with bubble=1 (RESET excluded). It saturates at 16'hFFFF and is cleared by rst.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

## Structure
- Package fetch_seq_pkg: opcode constants, state enum, PC_W default.
- Sub-module branch_decode: combinational, instr -> is_jump, is_branch, is_halt, jump_target. The FSM lives in fetch_sequencer.

## Test plan
- Reset release, then 3 sequential words: one bubble cycle, then pc_en=1 and bubble=0 on 3 consecutive cycles.
- OP_J with instr[6:0]=7'h40: same cycle pc_sel=1, pc_target=7'h40. Next cycle bubble=1, then RUN.
- BEQ, br_resolved & br_taken on the 3rd BR_WAIT cycle with br_target=7'h10: 3 bubbles, pc_target=7'h10, 1 REFILL bubble. Not-taken variant: 3 bubbles, then RUN with pc_en=0 on the resolve cycle.
- stall_in=1 for 2 cycles while instr=BNE: no decode, pc_en=0, if_id_en=0. On release, enters BR_WAIT.
- BEQ with no resolution, MAX_WAIT=4: err=1 and halted=1 after 4 wait cycles. rst then clears both.
- OP_HALT, then br_resolved pulse: stays HALT. With FETCH_SEQ_STATS_EN, bubble_cnt increments every HALT cycle.
